// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldiv_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_op_decode.sv
// Combinational funct3 decode for M-extension ops: op code plus signedness
// and result-selection flags.
module muldiv_op_decode
    import muldiv_pkg::*;
(
    input  logic [2:0]  funct3,
    output muldiv_op_e  op,
    output logic        is_div,
    output logic        a_signed,
    output logic        b_signed,
    output logic        want_high_or_rem
);

    // Map funct3 to op and flags; MUL is treated as unsigned since its low half is sign-agnostic.
    always_comb begin
        op               = OP_MUL;
        is_div           = 1'b0;
        a_signed         = 1'b0;
        b_signed         = 1'b0;
        want_high_or_rem = 1'b0;
        case (funct3)
            F3_MUL:    op = OP_MUL;
            F3_MULH:   begin op = OP_MULH;   a_signed = 1'b1; b_signed = 1'b1; want_high_or_rem = 1'b1; end
            F3_MULHSU: begin op = OP_MULHSU; a_signed = 1'b1; want_high_or_rem = 1'b1; end
            F3_MULHU:  begin op = OP_MULHU;  want_high_or_rem = 1'b1; end
            F3_DIV:    begin op = OP_DIV;    is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            F3_DIVU:   begin op = OP_DIVU;   is_div = 1'b1; end
            F3_REM:    begin op = OP_REM;    is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; want_high_or_rem = 1'b1; end
            F3_REMU:   begin op = OP_REMU;   is_div = 1'b1; want_high_or_rem = 1'b1; end
            default:   op = OP_MUL;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per CALC cycle, with a FIX cycle for sign correction.
// Divide-by-zero and signed overflow bypass straight to DONE.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete combinationally at accept.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   res_q, res_d;

    muldiv_op_e dec_op;
    logic       dec_is_div, dec_a_signed, dec_b_signed, dec_high;

    muldiv_op_decode u_decode (
        .funct3           (funct3),
        .op               (dec_op),
        .is_div           (dec_is_div),
        .a_signed         (dec_a_signed),
        .b_signed         (dec_b_signed),
        .want_high_or_rem (dec_high)
    );

    logic              a_neg, b_neg, div_zero, div_ovf, div_ge;
    logic [XLEN-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, prod_fix;

    // Operand magnitudes, fast-path detection and one iteration of each datapath.
    always_comb begin
        a_neg     = dec_a_signed & src_a[XLEN-1];
        b_neg     = dec_b_signed & src_b[XLEN-1];
        a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
        b_mag     = b_neg ? (~src_b + 1'b1) : src_b;
        div_zero  = dec_is_div && (src_b == '0);
        div_ovf   = dec_is_div && dec_a_signed && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = ~div_diff[XLEN];
        prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fm_a, fm_b, fm_prod;
    assign fm_a    = {{XLEN{dec_a_signed & src_a[XLEN-1]}}, src_a};
    assign fm_b    = {{XLEN{dec_b_signed & src_b[XLEN-1]}}, src_b};
    assign fm_prod = fm_a * fm_b;
`endif

    // Next-state and datapath update; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        res_d     = res_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d      = dec_op;
                    is_div_d  = dec_is_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    rem_d     = '0;
                    opb_d     = dec_is_div ? b_mag : a_mag;
                    acc_d     = {{XLEN{1'b0}}, (dec_is_div ? a_mag : b_mag)};
                    state_d   = ST_CALC;
                    if (div_zero) begin
                        res_d   = dec_high ? src_a : '1;
                        state_d = ST_DONE;
                    end else if (div_ovf) begin
                        res_d   = dec_high ? '0 : src_a;
                        state_d = ST_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (!dec_is_div) begin
                        res_d   = dec_high ? fm_prod[2*XLEN-1:XLEN] : fm_prod[XLEN-1:0];
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_CALC: begin
                if (is_div_q) begin
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
                    rem_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                end else begin
                    acc_d = mul_next;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                case (op_q)
                    OP_MUL:                      res_d = acc_q[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_fix[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:             res_d = quo_fix;
                    default:                     res_d = rem_fix;
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            res_q     <= res_d;
        end
    end

    // Handshake outputs are pure state decodes.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        result    = res_q;
    end

endmodule
